// File: rtl/calc_t_pkg.sv
// Shared defaults, fixed-point format constants and the reciprocal table
// generator for the inverse-transmission stream.
package calc_t_pkg;

    localparam int DW_DEF      = 12;
    localparam int KW_DEF      = 12;
    localparam int OW_DEF      = 12;
    localparam int RW_DEF      = 16;
    localparam int LUT_AW_DEF  = 10;
    localparam int DEN_MIN_DEF = 16;
    localparam int TW_DEF      = 8;

    localparam int Q4_INT_BITS = 4;
    localparam int Q8_INT_BITS = 8;
    localparam int ONE_Q4      = 1 << (OW_DEF - Q4_INT_BITS);

    function automatic int one_q4(input int ow);
        return 1 << (ow - Q4_INT_BITS);
    endfunction

    // Entry i holds 1/(i/2^aw) in Q8.(rw-8); index 0 behaves like index 1.
    function automatic logic [63:0] recip_entry(input int idx, input int aw, input int rw);
        logic [63:0] num;
        logic [63:0] div;
        logic [63:0] lim;
        logic [63:0] quo;
        num = 64'd1 << (aw + rw - Q8_INT_BITS);
        div = (idx == 0) ? 64'd1 : 64'(idx);
        lim = (64'd1 << rw) - 64'd1;
        quo = num / div;
        return (quo > lim) ? lim : quo;
    endfunction

endpackage

// File: rtl/recip_lut.sv
// Constant reciprocal ROM with a registered, enable-gated read port.
module recip_lut
    import calc_t_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int RW     = RW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [LUT_AW-1:0] addr,
    output logic [RW-1:0]     rd_data
);
    localparam int DEPTH = 1 << LUT_AW;

    logic [RW-1:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = RW'(recip_entry(gi, LUT_AW, RW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rom[addr];
        end
    end

endmodule

// File: rtl/calc_inv_t_stream.sv
// Five-stage streaming computation of inv_t = S_D / max(S_D - K*(S_D-S_H), DEN_MIN)
// with a single global stall enable driven by downstream backpressure.
module calc_inv_t_stream
    import calc_t_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int KW      = KW_DEF,
    parameter int OW      = OW_DEF,
    parameter int RW      = RW_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int DEN_MIN = DEN_MIN_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] S_H,
    input  logic [DW-1:0] S_D,
    input  logic [KW-1:0] K,
    input  logic          bypass,
    input  logic [TW-1:0] tag_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] inv_t,
    output logic          sat,
    output logic [TW-1:0] tag_out,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int PW      = KW + DW;
    localparam int QW      = DW + RW;
    localparam int Q_SHIFT = (DW + RW - Q8_INT_BITS) - (OW - Q4_INT_BITS);
    localparam logic [DW-1:0] DEN_FLOOR = DW'(DEN_MIN);
    localparam logic [OW-1:0] ONE_OUT   = OW'(one_q4(OW));

    logic              en;
    logic              v1_reg, v2_reg, v3_reg, v4_reg;
    logic [DW-1:0]     sd1_reg, sd2_reg, sd3_reg, sd4_reg;
    logic              byp1_reg, byp2_reg, byp3_reg, byp4_reg;
    logic [TW-1:0]     tag1_reg, tag2_reg, tag3_reg, tag4_reg;
    logic [KW-1:0]     k1_reg;
    logic [DW-1:0]     diff1_reg, prod2_reg;
    logic [LUT_AW-1:0] addr3_reg;
    logic              clamp3_reg, clamp4_reg;
    logic [RW-1:0]     recip4_data;

    logic [DW-1:0]     diff_next, prod_next, den_next;
    logic [PW-1:0]     prod_full;
    logic [QW-1:0]     q_full;
    logic              clamp_next, q_ovf;
    logic [OW-1:0]     inv_next;
    logic              sat_next;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        diff_next = (S_D >= S_H) ? S_D - S_H : '0;

        // Q4 product: any integer bit set means the Q0 result would exceed 1.0
        prod_full = PW'(k1_reg) * PW'(diff1_reg);
        prod_next = ((prod_full >> (PW - Q4_INT_BITS)) != '0) ? '1
                                                             : DW'(prod_full >> (KW - Q4_INT_BITS));

        clamp_next = 1'b0;
        den_next   = DEN_FLOOR;
        if (sd2_reg > prod2_reg) begin
            den_next = sd2_reg - prod2_reg;
        end else begin
            clamp_next = 1'b1;
        end
        if (den_next < DEN_FLOOR) begin
            den_next   = DEN_FLOOR;
            clamp_next = 1'b1;
        end

        // Q8 quotient saturates once its integer part reaches 16
        q_full = QW'(sd4_reg) * QW'(recip4_data);
        q_ovf  = (q_full >> (QW - (Q8_INT_BITS - Q4_INT_BITS))) != '0;

        if (byp4_reg) begin
            inv_next = ONE_OUT;
            sat_next = 1'b0;
        end else if (q_ovf) begin
            inv_next = '1;
            sat_next = 1'b1;
        end else begin
            inv_next = OW'(q_full >> Q_SHIFT);
            sat_next = clamp4_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            v3_reg     <= 1'b0;
            v4_reg     <= 1'b0;
            sd1_reg    <= '0;
            sd2_reg    <= '0;
            sd3_reg    <= '0;
            sd4_reg    <= '0;
            byp1_reg   <= 1'b0;
            byp2_reg   <= 1'b0;
            byp3_reg   <= 1'b0;
            byp4_reg   <= 1'b0;
            tag1_reg   <= '0;
            tag2_reg   <= '0;
            tag3_reg   <= '0;
            tag4_reg   <= '0;
            k1_reg     <= '0;
            diff1_reg  <= '0;
            prod2_reg  <= '0;
            addr3_reg  <= '0;
            clamp3_reg <= 1'b0;
            clamp4_reg <= 1'b0;
            out_valid  <= 1'b0;
            inv_t      <= '0;
            sat        <= 1'b0;
            tag_out    <= '0;
        end else if (en) begin
            v1_reg     <= in_valid;
            sd1_reg    <= S_D;
            k1_reg     <= K;
            byp1_reg   <= bypass || (S_D == '0);
            tag1_reg   <= tag_in;
            diff1_reg  <= diff_next;

            v2_reg     <= v1_reg;
            sd2_reg    <= sd1_reg;
            byp2_reg   <= byp1_reg;
            tag2_reg   <= tag1_reg;
            prod2_reg  <= prod_next;

            v3_reg     <= v2_reg;
            sd3_reg    <= sd2_reg;
            byp3_reg   <= byp2_reg;
            tag3_reg   <= tag2_reg;
            addr3_reg  <= den_next[DW-1 -: LUT_AW];
            clamp3_reg <= clamp_next;

            v4_reg     <= v3_reg;
            sd4_reg    <= sd3_reg;
            byp4_reg   <= byp3_reg;
            tag4_reg   <= tag3_reg;
            clamp4_reg <= clamp3_reg;

            out_valid  <= v4_reg;
            inv_t      <= inv_next;
            sat        <= sat_next;
            tag_out    <= tag4_reg;
        end
    end

    recip_lut #(
        .LUT_AW(LUT_AW),
        .RW    (RW)
    ) u_recip_lut (
        .clk    (clk),
        .rst    (rst),
        .rd_en  (en),
        .addr   (addr3_reg),
        .rd_data(recip4_data)
    );

endmodule

// File: tb/tb_calc_inv_t_stream.sv
// Directed and randomized stream checks of calc_inv_t_stream against an
// arithmetic reference model, including stalls and mid-flight reset.
module tb_calc_inv_t_stream;
    localparam int DW = 12, KW = 12, OW = 12, RW = 16, LUT_AW = 10, DEN_MIN = 16, TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] S_H, S_D;
    logic [KW-1:0] K;
    logic          bypass;
    logic [TW-1:0] tag_in;
    logic          in_valid, in_ready;
    logic [OW-1:0] inv_t;
    logic          sat;
    logic [TW-1:0] tag_out;
    logic          out_valid, out_ready;

    always #5 clk = ~clk;

    calc_inv_t_stream #(
        .DW(DW), .KW(KW), .OW(OW), .RW(RW), .LUT_AW(LUT_AW), .DEN_MIN(DEN_MIN), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .S_H(S_H), .S_D(S_D), .K(K), .bypass(bypass),
        .tag_in(tag_in), .in_valid(in_valid), .in_ready(in_ready), .inv_t(inv_t),
        .sat(sat), .tag_out(tag_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        int inv;
        int st;
        int tag;
        int acc_cyc;
        bit chk_lat;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            stall_cnt = 0;
    bit            rand_ready = 1'b0;
    bit            lat_mode = 1'b0;
    bit            accepted = 1'b0;
    bit            stalled_prev = 1'b0;
    logic [OW-1:0] held_inv;
    logic          held_sat;
    logic [TW-1:0] held_tag;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Real-valued intent: inv_t = S_D / den, with den = S_D - K*(S_D-S_H) floored at DEN_MIN.
    function automatic void model(input int sd, input int sh, input int k, input int byp,
                                  output int inv, output int st);
        longint diff, p, prod, den, idx, r, q;
        bit clamp;
        if (byp != 0 || sd == 0) begin
            inv = 1 << (OW - 4);
            st  = 0;
            return;
        end
        diff = (sd >= sh) ? longint'(sd - sh) : 0;
        p    = longint'(k) * diff;
        prod = (p >= (longint'(1) << (KW - 4 + DW))) ? longint'((1 << DW) - 1) : (p >> (KW - 4));
        clamp = 1'b0;
        if (longint'(sd) > prod) den = longint'(sd) - prod;
        else begin den = DEN_MIN; clamp = 1'b1; end
        if (den < DEN_MIN) begin den = DEN_MIN; clamp = 1'b1; end
        idx = den >> (DW - LUT_AW);
        r   = (longint'(1) << (LUT_AW + RW - 8)) / ((idx == 0) ? 1 : idx);
        if (r > (longint'(1) << RW) - 1) r = (longint'(1) << RW) - 1;
        q = longint'(sd) * r;
        if (q >= (longint'(16) << (DW + RW - 8))) begin
            inv = (1 << OW) - 1;
            st  = 1;
        end else begin
            inv = int'(q >> (DW + RW - 8 - (OW - 4)));
            st  = int'(clamp);
        end
    endfunction

    task automatic run_cycle();
        exp_t e;
        int   iv, st;
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        if (stalled_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_inv", inv_t, held_inv);
            check("hold_sat", sat, held_sat);
            check("hold_tag", tag_out, held_tag);
        end
        stalled_prev = out_valid && !out_ready;
        held_inv = inv_t;
        held_sat = sat;
        held_tag = tag_out;
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("inv_t", inv_t, e.inv);
                check("sat", sat, e.st);
                check("tag_out", tag_out, e.tag);
                if (e.chk_lat) check("latency", cyc - e.acc_cyc, 5);
            end
        end
        if (in_valid && in_ready) begin
            model(int'(S_D), int'(S_H), int'(K), int'(bypass), iv, st);
            e.inv = iv;
            e.st = st;
            e.tag = int'(tag_in);
            e.acc_cyc = cyc;
            e.chk_lat = lat_mode;
            exp_q.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input int sd, input int sh, input int k, input int byp, input int tg);
        S_D      = DW'(sd);
        S_H      = DW'(sh);
        K        = KW'(k);
        bypass   = (byp != 0);
        tag_in   = TW'(tg);
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            run_cycle();
            if (accepted) break;
        end
        check("accept", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) run_cycle();
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int sd, sh;
        rst = 1'b1;
        in_valid = 1'b0;
        S_H = '0; S_D = '0; K = '0; bypass = 1'b0; tag_in = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_inv_t", inv_t, 0);
        check("rst_sat", sat, 0);
        check("rst_tag_out", tag_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Directed points with latency checking and out_ready held high
        lat_mode = 1'b1;
        send(2048, 1024, 256, 0, 8'h11);
        drain();
        send(2048, 1024, 320, 0, 8'h22);
        drain();
        send(4095, 0, 256, 0, 8'h33);
        send(0, 100, 300, 0, 8'h5A);
        send(1000, 10, 200, 1, 8'h5A);
        send(3000, 3500, 4095, 0, 8'h44);
        drain();
        lat_mode = 1'b0;

        // Ten back-to-back beats with a 3-cycle downstream stall mid-stream
        for (int i = 0; i < 10; i++) begin
            if (i == 7) stall_cnt = 3;
            send($urandom_range(1, 4095), $urandom_range(0, 4095), $urandom_range(0, 1023), 0, 8'hA0 + i);
        end
        drain();

        // Randomized beats, random gaps, random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sd = (i % 11 == 0) ? 0 : int'($urandom_range(0, 4095));
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, sd));
            send(sd, sh, $urandom_range(0, 4095) >> $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) run_cycle();
        end
        drain();
        rand_ready = 1'b0;

        // Reset with three beats in flight while the output is stalled
        stall_cnt = 1000;
        out_ready = 1'b0;
        send(2048, 1024, 256, 0, 8'hC1);
        send(2048, 1024, 320, 0, 8'hC2);
        send(4095, 0, 256, 0, 8'hC3);
        for (int i = 0; i < 6; i++) run_cycle();
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_inv", inv_t, 0);
        check("async_rst_sat", sat, 0);
        check("async_rst_tag", tag_out, 0);
        exp_q.delete();
        stalled_prev = 1'b0;
        stall_cnt = 0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst2", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            check("post_rst_valid", out_valid, 0);
        end
        send(2048, 1024, 256, 0, 8'hD4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
